// File: rtl/truth_table_driver.sv
// Purpose: sweeps all 16 {a,b,c,d} vectors into a combinational lab block and checks f_dut against d & ~((a & b) | c).
// Latency: each vector is held SETTLE+1 cycles, so done rises 16*(SETTLE+1) edges after start is accepted.
// Backpressure: none; start is ignored while busy, and TTD_STOP_ON_FAIL_EN ends the sweep at the first mismatch.
module truth_table_driver #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    input  logic       f_dut,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Value the settle counter holds on the last DRIVE cycle of a vector.
    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [3:0] idx, idx_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic [4:0] err_nxt;
    logic [3:0] fv_nxt;
    logic       busy_nxt, done_nxt;
    logic       expected, mismatch;

    // The stimulus pins are the index register bits, so they come straight from flops.
    assign a = idx[3];
    assign b = idx[2];
    assign c = idx[1];
    assign d = idx[0];

    assign expected = idx[0] & ~((idx[3] & idx[2]) | idx[1]);
    assign mismatch = f_dut ^ expected;
    assign pass     = done & (err_count == 5'd0);

    // Sequencer state and result registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 4'd0;
            cnt       <= 4'd0;
            err_count <= 5'd0;
            fail_vec  <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            cnt       <= cnt_nxt;
            err_count <= err_nxt;
            fail_vec  <= fv_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
        end
    end

    // Next-state and datapath updates: hold the vector SETTLE cycles, then sample once.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        err_nxt   = err_count;
        fv_nxt    = fail_vec;
        busy_nxt  = busy;
        done_nxt  = done;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    idx_nxt   = 4'd0;
                    cnt_nxt   = 4'd0;
                    err_nxt   = 5'd0;
                    fv_nxt    = 4'd0;
                    done_nxt  = 1'b0;
                    busy_nxt  = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == SETTLE_LAST) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    err_nxt = err_count + 5'd1;
                    if (err_count == 5'd0) begin
                        fv_nxt = idx;
                    end
                end
`ifdef TTD_STOP_ON_FAIL_EN
                if (mismatch || idx == 4'd15) begin
`else
                if (idx == 4'd15) begin
`endif
                    state_nxt = DONE;
                    busy_nxt  = 1'b0;
                    done_nxt  = 1'b1;
                end else begin
                    idx_nxt   = idx + 4'd1;
                    cnt_nxt   = 4'd0;
                    state_nxt = DRIVE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
